mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Initiator-side controller that drives the team's dual-port byte RAM (memoria) from a single-clock CPU request interface.
- Accepts single-byte write requests and burst read requests (1..16 bytes) via a valid/ready handshake.
- Drives memoria's write port (data, write_addr, EscMen) and read port (read_addr), and returns read bytes with a response valid/last strobe.
- Sits between the CPU datapath and memoria. memoria's write_clock and read_clock are both tied to this block's clock.

Parameters:
- DATA_WIDTH, 8: memory word width.
- ADDR_WIDTH, 12: memory address width.
- LEN_WIDTH, 4: burst length field width. Burst size = req_len+1.

Ports:
- clock  in  1  system clock; all registers update on posedge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = write one byte, 0 = burst read.
- req_addr  in  ADDR_WIDTH  start address.
- req_wdata  in  DATA_WIDTH  write byte (writes only).
- req_len  in  LEN_WIDTH  read burst length minus 1 (ignored for writes).
- resp_valid  out  1  resp_rdata valid this cycle.
- resp_rdata  out  DATA_WIDTH  read byte.
- resp_last  out  1  final byte of the burst (qualified by resp_valid).
- mem_data  out  DATA_WIDTH  to memoria data.
- mem_write_addr  out  ADDR_WIDTH  to memoria write_addr.
- mem_EscMen  out  1  to memoria EscMen.
- mem_read_addr  out  ADDR_WIDTH  to memoria read_addr.
- mem_saida  in  DATA_WIDTH  from memoria saida.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. Outputs all 0 except req_ready=1. All memory-side outputs are registered.
- States: IDLE, RD_ISSUE, RD_DRAIN.
- IDLE:
  - req_ready=1. Handshake = req_valid & req_ready sampled at posedge T.
  - Write accepted at T: mem_write_addr<=req_addr, mem_data<=req_wdata, mem_EscMen<=1. memoria writes on the negedge inside cycle T..T+1.
  - Stay IDLE after a write. mem_EscMen clears at T+1 unless another write is accepted at T+1.
  - Back-to-back writes run at one per cycle.
  - Read accepted at T: mem_read_addr<=req_addr, remaining<=req_len, state<=RD_ISSUE if req_len!=0, else RD_DRAIN.
- RD_ISSUE:
  - req_ready=0.
  - Each posedge: mem_read_addr<=mem_read_addr+1. Wraps modulo 2**ADDR_WIDTH (4095 -> 0).
  - remaining decrements. Go to RD_DRAIN when the last address has been issued.
- Read pipeline (2-stage valid shift register):
  - Address issued at edge E is sampled by memoria at E+1.
  - mem_saida is captured into resp_rdata at E+2.
  - resp_valid is high for the cycle following E+2.
  - Read latency: accept edge T to first resp_valid = 2 clocks. Throughput: one byte per cycle, no gaps.
- resp_last: set with the resp_valid of the final byte only. A 1-byte burst has resp_valid and resp_last together.
- RD_DRAIN: req_ready=0. Return to IDLE on the edge that registers the final response. req_ready=1 in the same cycle as the final resp_valid.
- No response backpressure: the consumer must always accept responses.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data, because the negedge write precedes the read sample.
- Writes never produce a response.
- req_len is ignored on writes.
- Inputs are ignored when req_ready=0.
- Reset mid-burst: aborts immediately. No further resp_valid, mem_EscMen=0, and req_ready=1 after release.

Decomposition:
- Shared package (mem_pkg):
  - state enum (IDLE, RD_ISSUE, RD_DRAIN)
  - read latency constant RD_LAT=2
  - default widths DATA_WIDTH/ADDR_WIDTH/LEN_WIDTH
- Sub-module mem_rd_pipe: the 2-stage valid/last shift register plus resp_rdata capture. It takes issue/issue_last from the FSM and returns resp_valid/resp_last.
- The bench instantiates memoria alongside this block.

Test Plan:
- Reset release -> req_ready=1, mem_EscMen=0, resp_valid=0. Write addr 0x010 data 0xA5 -> mem_EscMen high one cycle, RAM[0x010]=0xA5.
- Writes to 0x000..0x003 data 0x11,0x22,0x33,0x44 on consecutive cycles -> mem_EscMen high 4 cycles, req_ready constantly 1. Read 0x000 len=3 -> resp 0x11,0x22,0x33,0x44 on 4 consecutive cycles, first 2 clocks after accept, resp_last on 0x44.
- Read 0xFFE len=3 with RAM[0xFFE]=0x01, [0xFFF]=0x02, [0x000]=0x03, [0x001]=0x04 -> 0x01,0x02,0x03,0x04 (address wrap), req_ready low until the final response cycle.
- Write 0x050=0x7E then read 0x050 len=0 on the next cycle -> single resp 0x7E with resp_valid and resp_last together.
- Assert req_valid with a write while a burst is in progress -> ignored, RAM unchanged, burst data intact.
- Assert reset during the 2nd cycle of a 16-byte burst -> resp_valid drops immediately and stays 0, req_ready=1 after release, and a subsequent read returns correct data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the memoria access controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_DRAIN = 2'd2
    } state_t;

    // Edges between issuing a read address and registering its response.
    localparam int RD_LAT = 2;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int DEF_LEN_WIDTH  = 4;

    typedef struct packed {
        logic vld;
        logic last;
    } rd_stage_t;

endpackage

// File: rtl/mem_rd_pipe.sv
// Tracks issued read addresses through memoria's read latency and registers the returned byte.
// Latency: RD_LAT edges from the issue edge to resp_valid.
// Backpressure: none; the consumer must take every response.
module mem_rd_pipe
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue,
    input  logic                  issue_last,
    input  logic [DATA_WIDTH-1:0] mem_saida,
    output logic                  resp_valid,
    output logic                  resp_last,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  final_pending
);

    // stage[0] follows the address on read_addr, stage[RD_LAT-1] the byte on saida.
    rd_stage_t stage [RD_LAT];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                stage[i] <= '0;
            end
            resp_valid <= 1'b0;
            resp_last  <= 1'b0;
            resp_rdata <= '0;
        end else begin
            stage[0] <= '{vld: issue, last: issue & issue_last};
            for (int i = 1; i < RD_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
            resp_valid <= stage[RD_LAT-1].vld;
            resp_last  <= stage[RD_LAT-1].vld & stage[RD_LAT-1].last;
            if (stage[RD_LAT-1].vld) begin
                resp_rdata <= mem_saida;
            end
        end
    end

    assign final_pending = stage[RD_LAT-1].vld & stage[RD_LAT-1].last;

endmodule

// File: rtl/memoria.sv
// Dual-port byte RAM: write on the falling write_clock edge, registered read on the rising read_clock edge.
// Latency: saida reflects read_addr one read_clock edge after it is sampled.
// Backpressure: none; accepts a write and a read every cycle.
module memoria #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  write_clock,
    input  logic                  read_clock,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic                  EscMen,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [DATA_WIDTH-1:0] saida
);

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];

    always_ff @(negedge write_clock) begin
        if (EscMen) begin
            ram[write_addr] <= data;
        end
    end

    always_ff @(posedge read_clock) begin
        saida <= ram[read_addr];
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// CPU-side controller for memoria: single-byte writes and 1..16 byte burst reads.
// Latency: write lands on the negedge after accept; first read byte 2 clocks after accept, then 1/cycle.
// Backpressure: req_ready low for a whole read burst; responses cannot be stalled.
module mem_access_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [LEN_WIDTH-1:0]  req_len,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_last,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic                  mem_EscMen,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_saida
);

    state_t               state, state_nxt;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 issue;
    logic                 issue_last;
    logic                 final_pending;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_write) begin
                        wr_acc = 1'b1;
                    end else begin
                        rd_acc     = 1'b1;
                        issue      = 1'b1;
                        issue_last = (req_len == '0);
                        state_nxt  = (req_len == '0) ? RD_DRAIN : RD_ISSUE;
                    end
                end
            end
            RD_ISSUE: begin
                // remaining counts addresses still to issue after the current one.
                issue      = 1'b1;
                issue_last = (remaining == LEN_WIDTH'(1));
                if (issue_last) begin
                    state_nxt = RD_DRAIN;
                end
            end
            RD_DRAIN: begin
                if (final_pending) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_EscMen     <= 1'b0;
            mem_write_addr <= '0;
            mem_data       <= '0;
            mem_read_addr  <= '0;
            remaining      <= '0;
        end else begin
            mem_EscMen <= wr_acc;
            if (wr_acc) begin
                mem_write_addr <= req_addr;
                mem_data       <= req_wdata;
            end
            if (rd_acc) begin
                mem_read_addr <= req_addr;
                remaining     <= req_len;
            end else if (state == RD_ISSUE) begin
                mem_read_addr <= mem_read_addr + ADDR_WIDTH'(1);
                remaining     <= remaining - LEN_WIDTH'(1);
            end
        end
    end

    mem_rd_pipe #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_rd_pipe (
        .clock        (clock),
        .reset        (reset),
        .issue        (issue),
        .issue_last   (issue_last),
        .mem_saida    (mem_saida),
        .resp_valid   (resp_valid),
        .resp_last    (resp_last),
        .resp_rdata   (resp_rdata),
        .final_pending(final_pending)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl driving a memoria instance: a transaction table plus corner-case sequences.
module tb_mem_access_ctrl;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic [3:0]  req_len;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        resp_last;
    logic [7:0]  mem_data;
    logic [11:0] mem_write_addr;
    logic        mem_EscMen;
    logic [11:0] mem_read_addr;
    logic [7:0]  mem_saida;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic             wr;
        logic [11:0]      addr;
        logic [7:0]       wdata;
        logic [3:0]       len;
        logic [15:0][7:0] exp;
    } vec_t;

    vec_t vecs [13];

    mem_access_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_len       (req_len),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_last     (resp_last),
        .mem_data      (mem_data),
        .mem_write_addr(mem_write_addr),
        .mem_EscMen    (mem_EscMen),
        .mem_read_addr (mem_read_addr),
        .mem_saida     (mem_saida)
    );

    memoria #(
        .DATA_WIDTH(8),
        .ADDR_WIDTH(12)
    ) u_mem (
        .write_clock(clock),
        .read_clock (clock),
        .data       (mem_data),
        .write_addr (mem_write_addr),
        .EscMen     (mem_EscMen),
        .read_addr  (mem_read_addr),
        .saida      (mem_saida)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called #1 after an edge; returns #1 after the accept edge.
    task automatic do_write(input logic [11:0] addr, input logic [7:0] data);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_wdata = data;
        req_len   = 4'hF;
        @(posedge clock); #1;
        chk("wr_escmen", 32'(mem_EscMen), 32'd1);
        chk("wr_addr", 32'(mem_write_addr), 32'(addr));
        chk("wr_data", 32'(mem_data), 32'(data));
        chk("wr_ready", 32'(req_ready), 32'd1);
        chk("wr_no_resp", 32'(resp_valid), 32'd0);
        req_valid = 1'b0;
    endtask

    // Checks exact response timing; optionally holds a write request up during the burst.
    task automatic do_read(input logic [11:0] addr, input logic [3:0] len,
                           input logic [15:0][7:0] exp, input bit inject);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        req_len   = len;
        req_wdata = 8'h5A;
        @(posedge clock); #1;
        chk("rd_busy", 32'(req_ready), 32'd0);
        chk("rd_escmen_clear", 32'(mem_EscMen), 32'd0);
        chk("rd_no_early_resp", 32'(resp_valid), 32'd0);
        if (inject) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_addr  = 12'h000;
            req_wdata = 8'hEE;
        end else begin
            req_valid = 1'b0;
        end
        @(posedge clock); #1;
        chk("rd_lat_gap", 32'(resp_valid), 32'd0);
        chk("rd_escmen_idle", 32'(mem_EscMen), 32'd0);
        for (int i = 0; i <= int'(len); i++) begin
            @(posedge clock); #1;
            chk("rd_valid", 32'(resp_valid), 32'd1);
            chk("rd_data", 32'(resp_rdata), 32'(exp[i]));
            chk("rd_last", 32'(resp_last), 32'(i == int'(len)));
            chk("rd_ready", 32'(req_ready), 32'(i == int'(len)));
            chk("rd_escmen_burst", 32'(mem_EscMen), 32'd0);
            if (i == int'(len)) begin
                req_valid = 1'b0;
            end
        end
        @(posedge clock); #1;
        chk("rd_end_valid", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 12'h000, 8'h11, 4'd0, 128'h0};
        vecs[1]  = '{1'b1, 12'h001, 8'h22, 4'd0, 128'h0};
        vecs[2]  = '{1'b1, 12'h002, 8'h33, 4'd0, 128'h0};
        vecs[3]  = '{1'b1, 12'h003, 8'h44, 4'd0, 128'h0};
        vecs[4]  = '{1'b0, 12'h000, 8'h00, 4'd3, 128'h44332211};
        vecs[5]  = '{1'b1, 12'hFFE, 8'h01, 4'd0, 128'h0};
        vecs[6]  = '{1'b1, 12'hFFF, 8'h02, 4'd0, 128'h0};
        vecs[7]  = '{1'b1, 12'h000, 8'h03, 4'd0, 128'h0};
        vecs[8]  = '{1'b1, 12'h001, 8'h04, 4'd0, 128'h0};
        vecs[9]  = '{1'b0, 12'hFFE, 8'h00, 4'd3, 128'h04030201};
        vecs[10] = '{1'b1, 12'h050, 8'h7E, 4'd0, 128'h0};
        vecs[11] = '{1'b0, 12'h050, 8'h00, 4'd0, 128'h7E};
        vecs[12] = '{1'b0, 12'h001, 8'h00, 4'd2, 128'h443304};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_len   = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_escmen", 32'(mem_EscMen), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_last", 32'(resp_last), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        chk("post_rst_escmen", 32'(mem_EscMen), 32'd0);

        // Single write: one-cycle EscMen pulse and the byte lands in the RAM.
        do_write(12'h010, 8'hA5);
        @(posedge clock); #1;
        chk("wr_pulse_end", 32'(mem_EscMen), 32'd0);
        chk("ram_010", 32'(u_mem.ram[12'h010]), 32'hA5);

        for (int v = 0; v < 13; v++) begin
            if (vecs[v].wr) begin
                do_write(vecs[v].addr, vecs[v].wdata);
            end else begin
                do_read(vecs[v].addr, vecs[v].len, vecs[v].exp, 1'b0);
            end
        end

        // Write request held during a burst must be ignored.
        do_read(12'h000, 4'd3, 128'h44330403, 1'b1);
        chk("inject_ram_000", 32'(u_mem.ram[12'h000]), 32'h03);

        // Reset during the second response cycle of a 16-byte burst.
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'h000;
        req_len   = 4'hF;
        @(posedge clock); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("burst_second_valid", 32'(resp_valid), 32'd1);
        chk("burst_second_data", 32'(resp_rdata), 32'h04);
        reset = 1'b1;
        #1;
        chk("abort_valid", 32'(resp_valid), 32'd0);
        chk("abort_last", 32'(resp_last), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_escmen", 32'(mem_EscMen), 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clock); #1;
            chk("after_abort_valid", 32'(resp_valid), 32'd0);
            chk("after_abort_ready", 32'(req_ready), 32'd1);
        end
        do_read(12'h000, 4'd3, 128'h44330403, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
